// File: rtl/mcp3008_emulator_if.sv
`default_nettype none
// ============================================================================
// Module   : mcp3008_emulator_if
// Brief    : SPI pin bundle between an MCP3008 master and the emulated device.
// Revision : 1.0 - initial release
// ============================================================================
interface mcp3008_emulator_if;
    logic dclk;
    logic cs_n;
    logic din;
    logic dout;
    logic dout_oe;

    modport master (
        output dclk,
        output cs_n,
        output din,
        input  dout,
        input  dout_oe
    );

    modport slave (
        input  dclk,
        input  cs_n,
        input  din,
        output dout,
        output dout_oe
    );
endinterface
`default_nettype wire

// File: rtl/mcp3008_emulator.sv
`default_nettype none
// ============================================================================
// Module   : mcp3008_emulator
// Brief    : MCP3008 SPI responder returning 10-bit values from a parallel bus.
//            Optional MCP_EMU_LSB_FIRST_EN adds the LSB-first echo in the tail.
// Revision : 1.0 - initial release
// ============================================================================
module mcp3008_emulator #(
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    mcp3008_emulator_if.slave  spi,
    input  logic [79:0]        ch_values,
    output logic               conv_strobe,
    output logic [3:0]         last_cmd,
    output logic [CNT_W-1:0]   conv_count,
    output logic               busy
);

    localparam logic [2:0] c_ST_LOCKOUT    = 3'd0;
    localparam logic [2:0] c_ST_IDLE       = 3'd1;
    localparam logic [2:0] c_ST_WAIT_START = 3'd2;
    localparam logic [2:0] c_ST_CMD        = 3'd3;
    localparam logic [2:0] c_ST_SAMPLE     = 3'd4;
    localparam logic [2:0] c_ST_SHIFT      = 3'd5;
    localparam logic [2:0] c_ST_TAIL       = 3'd6;

    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic r_dclk_meta, r_dclk_sync, r_dclk_hist;
    logic r_cs_meta, r_cs_sync, r_cs_hist;
    logic r_din_meta, r_din_sync;

    // cs_n sync flops clear to 0 so LOCKOUT only exits on a real high level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dclk_meta <= 1'b0;
            r_dclk_sync <= 1'b0;
            r_dclk_hist <= 1'b0;
            r_cs_meta   <= 1'b0;
            r_cs_sync   <= 1'b0;
            r_cs_hist   <= 1'b0;
            r_din_meta  <= 1'b0;
            r_din_sync  <= 1'b0;
        end else begin
            r_dclk_meta <= spi.dclk;
            r_dclk_sync <= r_dclk_meta;
            r_dclk_hist <= r_dclk_sync;
            r_cs_meta   <= spi.cs_n;
            r_cs_sync   <= r_cs_meta;
            r_cs_hist   <= r_cs_sync;
            r_din_meta  <= spi.din;
            r_din_sync  <= r_din_meta;
        end
    end

    logic w_rise, w_fall, w_cs_rise, w_cs_fall, w_cs_low;
    assign w_rise    =  r_dclk_sync & ~r_dclk_hist;
    assign w_fall    = ~r_dclk_sync &  r_dclk_hist;
    assign w_cs_rise =  r_cs_sync   & ~r_cs_hist;
    assign w_cs_fall = ~r_cs_sync   &  r_cs_hist;
    assign w_cs_low  = ~r_cs_sync;

    logic [2:0]       r_state;
    logic [3:0]       r_cmd;
    logic [3:0]       r_bit_cnt;
    logic             r_phase;
    logic [9:0]       r_result;
    logic             r_dout;
    logic             r_dout_oe;
    logic             r_busy;
    logic             r_strobe;
    logic [3:0]       r_last_cmd;
    logic [CNT_W-1:0] r_conv_count;

    logic [9:0] w_ch [0:7];
    for (genvar gi = 0; gi < 8; gi++) begin : g_ch
        assign w_ch[gi] = ch_values[10*gi +: 10];
    end

    // Pseudo-differential pair: 11-bit difference, negative clamps to zero
    logic [9:0]  w_even, w_odd, w_conv;
    logic [10:0] w_diff;
    assign w_even = w_ch[{r_cmd[2:1], 1'b0}];
    assign w_odd  = w_ch[{r_cmd[2:1], 1'b1}];
    assign w_diff = r_cmd[0] ? ({1'b0, w_odd} - {1'b0, w_even})
                             : ({1'b0, w_even} - {1'b0, w_odd});
    assign w_conv = r_cmd[3] ? w_ch[r_cmd[2:0]]
                             : (w_diff[10] ? 10'd0 : w_diff[9:0]);

    logic [2:0]       w_state_nxt;
    logic [3:0]       w_cmd_nxt;
    logic [3:0]       w_bit_cnt_nxt;
    logic             w_phase_nxt;
    logic [9:0]       w_result_nxt;
    logic             w_dout_nxt;
    logic             w_oe_nxt;
    logic             w_busy_nxt;
    logic             w_strobe_nxt;
    logic [3:0]       w_last_cmd_nxt;
    logic [CNT_W-1:0] w_count_nxt;

    always_comb begin
        w_state_nxt    = r_state;
        w_cmd_nxt      = r_cmd;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_phase_nxt    = r_phase;
        w_result_nxt   = r_result;
        w_dout_nxt     = r_dout;
        w_oe_nxt       = r_dout_oe;
        w_busy_nxt     = r_busy;
        w_strobe_nxt   = 1'b0;
        w_last_cmd_nxt = r_last_cmd;
        w_count_nxt    = r_conv_count;

        if (r_state == c_ST_LOCKOUT) begin
            if (r_cs_sync) begin
                w_state_nxt = c_ST_IDLE;
            end
        end else if (w_cs_rise) begin
            // Deselect wins over any dclk edge seen in the same cycle
            w_state_nxt = c_ST_IDLE;
            w_oe_nxt    = 1'b0;
            w_dout_nxt  = 1'b0;
            w_busy_nxt  = 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_cs_fall) begin
                        w_state_nxt = c_ST_WAIT_START;
                    end
                end
                c_ST_WAIT_START: begin
                    if (w_cs_low && w_rise && r_din_sync) begin
                        w_state_nxt   = c_ST_CMD;
                        w_busy_nxt    = 1'b1;
                        w_bit_cnt_nxt = 4'd0;
                    end
                end
                c_ST_CMD: begin
                    if (w_cs_low && w_rise) begin
                        w_cmd_nxt     = {r_cmd[2:0], r_din_sync};
                        w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                        if (r_bit_cnt == 4'd3) begin
                            w_state_nxt = c_ST_SAMPLE;
                            w_phase_nxt = 1'b0;
                        end
                    end
                end
                c_ST_SAMPLE: begin
                    if (w_cs_low && w_fall) begin
                        if (!r_phase) begin
                            w_result_nxt   = w_conv;
                            w_last_cmd_nxt = r_cmd;
                            w_strobe_nxt   = 1'b1;
                            w_count_nxt    = r_conv_count + c_CNT_ONE;
                            w_phase_nxt    = 1'b1;
                        end else begin
                            w_oe_nxt      = 1'b1;
                            w_dout_nxt    = 1'b0;
                            w_state_nxt   = c_ST_SHIFT;
                            w_bit_cnt_nxt = 4'd0;
                        end
                    end
                end
                c_ST_SHIFT: begin
                    if (w_cs_low && w_fall) begin
                        w_dout_nxt    = r_result[4'd9 - r_bit_cnt];
                        w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                        if (r_bit_cnt == 4'd9) begin
                            w_state_nxt   = c_ST_TAIL;
                            w_bit_cnt_nxt = 4'd0;
                        end
                    end
                end
                c_ST_TAIL: begin
                    if (w_cs_low && w_fall) begin
`ifdef MCP_EMU_LSB_FIRST_EN
                        if (r_bit_cnt < 4'd9) begin
                            w_dout_nxt    = r_result[r_bit_cnt + 4'd1];
                            w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                        end else begin
                            w_dout_nxt = 1'b0;
                        end
`else
                        w_dout_nxt = 1'b0;
`endif
                    end
                end
                default: begin
                    w_state_nxt = c_ST_LOCKOUT;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_ST_LOCKOUT;
            r_cmd        <= 4'd0;
            r_bit_cnt    <= 4'd0;
            r_phase      <= 1'b0;
            r_result     <= 10'd0;
            r_dout       <= 1'b0;
            r_dout_oe    <= 1'b0;
            r_busy       <= 1'b0;
            r_strobe     <= 1'b0;
            r_last_cmd   <= 4'd0;
            r_conv_count <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_cmd        <= w_cmd_nxt;
            r_bit_cnt    <= w_bit_cnt_nxt;
            r_phase      <= w_phase_nxt;
            r_result     <= w_result_nxt;
            r_dout       <= w_dout_nxt;
            r_dout_oe    <= w_oe_nxt;
            r_busy       <= w_busy_nxt;
            r_strobe     <= w_strobe_nxt;
            r_last_cmd   <= w_last_cmd_nxt;
            r_conv_count <= w_count_nxt;
        end
    end

    assign spi.dout    = r_dout;
    assign spi.dout_oe = r_dout_oe;
    assign conv_strobe = r_strobe;
    assign last_cmd    = r_last_cmd;
    assign conv_count  = r_conv_count;
    assign busy        = r_busy;

endmodule
`default_nettype wire

// File: doc/mcp3008_emulator.md
# mcp3008_emulator

- Synthesizable MCP3008 SPI responder: the device side of the ADC serial protocol our MCP3008 master drives.
- Samples the master's `dclk`/`cs_n`/`din` in the system clock domain, decodes start/SGL/channel bits, and shifts back a 10-bit result taken from a parallel channel-value bus.
- Used on the breadboard and in simulation in place of a real ADC, so the MCP read path and FT245 forwarding are tested with known data.

## Interface
- `CNT_W`, default 16: width of the conversion counter.
- `clk  input  1`: system clock; must be ≥ 8× the `dclk` frequency.
- `rst  input  1`: asynchronous, active-high reset.
- `dclk  input  1`: SPI clock from the master; asynchronous to `clk`.
- `cs_n  input  1`: active-low chip select from the master; asynchronous.
- `din  input  1`: master-to-device serial data; asynchronous.
- `dout  output  1`: device-to-master serial data.
- `dout_oe  output  1`: output enable for `dout`. The top level tri-states `dout` when this is 0.
- `ch_values  input  80`: eight 10-bit channel values; CHn = `ch_values[10n+9:10n]`.
- `conv_strobe  output  1`: one-`clk` pulse when a conversion value is latched.
- `last_cmd  output  4`: {SGL, D2, D1, D0} of the last decoded command.
- `conv_count  output  CNT_W`: completed conversions, wraps modulo 2^CNT_W.
- `busy  output  1`: high from start-bit capture until the frame ends.

## Operation
- **Input synchronization:** `dclk`, `cs_n` and `din` pass through 2-flop synchronizers. Rising/falling `dclk` edges are detected from the synchronized value plus one history flop. Every action below occurs on a detected edge, and only while synced `cs_n` = 0.
- **States:**
  - `LOCKOUT`: entered from reset. Leave to `IDLE` only when synced `cs_n` = 1, so a frame already running at reset release is ignored.
  - `IDLE`: on synced `cs_n` falling → `WAIT_START`.
  - `WAIT_START`: on each `dclk` rise, if `din` = 1 → `CMD`, `busy` = 1. Leading zeros are ignored.
  - `CMD`: capture SGL, D2, D1, D0 on the next 4 `dclk` rises, MSB first. After D0 → `SAMPLE`.
  - `SAMPLE`: on the 1st `dclk` fall, latch the result into a 10-bit shift register, update `last_cmd`, pulse `conv_strobe`, increment `conv_count`.
    - On the 2nd fall: `dout_oe` = 1, `dout` = 0 (null bit), → `SHIFT`.
  - `SHIFT`: on each following fall, drive B9 down to B0 (10 falls). Afterwards → `TAIL`.
  - `TAIL`: behaviour set by Configuration. Stays in `TAIL` until `cs_n` rises.
- **Abort:** synced `cs_n` rising in any state except `LOCKOUT` → `IDLE`, `dout_oe` = 0, `busy` = 0. If this happens before the `SAMPLE` latch, `conv_count` and `conv_strobe` are untouched.
- **Result arithmetic:**
  - SGL = 1: result = CH{D2,D1,D0}.
  - SGL = 0 (pseudo-differential): pair p = {D2,D1}, members CH(2p) and CH(2p+1).
    - D0 = 0: result = CH(2p) − CH(2p+1).
    - D0 = 1: result = CH(2p+1) − CH(2p).
    - Computed in 11 bits; a negative result saturates to 0.
- **Value timing:** `ch_values` is sampled only at the latch cycle. Changes after the latch do not affect the frame in progress.
- **Reset values:** `dout` = 0, `dout_oe` = 0, `conv_strobe` = 0, `last_cmd` = 0, `conv_count` = 0, `busy` = 0, state `LOCKOUT`.

## Timing
- Pin `dclk` fall → `dout`/`dout_oe` update: exactly 3 `clk` cycles (2 sync + 1 register).
- Pin `dclk` rise → bit capture: 3 `clk` cycles.
- Pin `cs_n` rise → `dout_oe` = 0: 3 `clk` cycles.
- `conv_strobe` asserts in the same cycle the shift register loads.
- Master view of a 24-clock frame (start bit on clock 8): null bit read at rise 14, B9 at rise 15, B0 at rise 24. This matches the 3-byte read our master uses.
- A `dclk` edge and a `cs_n` rise detected in the same cycle: the `cs_n` rise wins and the edge is ignored.
- `dclk` pulses narrower than 3 `clk` periods (high or low) are out of spec; behaviour is undefined.

## Configuration
- `MCP_EMU_LSB_FIRST_EN` defined: in `TAIL`, the following falls drive B1 up to B9 (the device's LSB-first echo), then `dout` = 0 until `cs_n` rises.
- Not defined: `dout` = 0 for every fall in `TAIL`.
- No other behaviour changes with the macro.

## Test plan
- **Single-ended:** CH5 = 10'h2A5. 24-clock frame with command SGL = 1, ch = 5.
  - Master receives byte0 = don't-care, byte1[1:0] = 2'b10, byte2 = 8'hA5.
  - `conv_strobe` pulses once; `conv_count` = 1; `last_cmd` = 4'b1101.
- **Pseudo-differential:** CH2 = 300, CH3 = 100, command SGL = 0, D2D1D0 = 010 → result 200.
  - Same values with D0 = 1 → result 0 (saturated).
- **Abort:** raise `cs_n` after the SGL bit.
  - `dout_oe` = 0 within 3 `clk`, `conv_count` unchanged.
  - The next full frame returns the correct value.
- **Reset mid-frame:** assert `rst` during `SHIFT` with `cs_n` low, release it, keep clocking.
  - No `dout_oe`, no strobe until `cs_n` goes high, then low.
- **Tail and counter:** CH0 = 10'h3FF, 32-clock frame.
  - With `MCP_EMU_LSB_FIRST_EN`: tail bits B1..B9 = all 1, then 0.
  - Without it: tail is all 0.
  - Preload `conv_count` to 2^CNT_W − 1 via 65535 frames, run one more frame: count wraps to 0.
